alu_muldiv_unit: RTL and testbench
==================================

Name: alu_muldiv_unit

Overview:
- Parametrised next-generation execution unit: full integer ALU plus RV32M-style multiply and divide, issuing results onto the CDB.
- Sits between the ALU reservation station and the CDB arbiter.
- Adds a valid/ready issue handshake, multi-cycle ops, result hold until the CDB accepts it, and flush mid-operation.

Parameters:
XLEN, 32, operand/result width (power of two, >= 8)
TAG_W, 4, ROB/RS tag width
MUL_LAT, 3, multiply latency in cycles from accept to out_valid (>= 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; when low all state frozen, outputs held
in_valid  in  1  issue request
in_ready  out  1  unit can accept this cycle
a  in  XLEN  operand A
b  in  XLEN  operand B
alu_op  in  5  opcode
tag  in  TAG_W  destination tag
flush  in  1  kill everything in flight
out_valid  out  1  result present on CDB
out_ack  in  1  CDB arbiter accepted result this cycle
cdb_data  out  XLEN  result
cdb_tag  out  TAG_W  result tag

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, cdb_data=0, cdb_tag=0, state=IDLE, counters 0. in_ready=1 after reset.
- Opcodes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra.
  - 8 slt, 9 sltu, 10 eq, 11 ne, 12 ge, 13 geu, 14 slt, 15 sltu.
  - 16 mul, 17 mulh, 18 mulhsu, 19 mulhu.
  - 20 div, 21 divu, 22 rem, 23 remu.
  - 24-31 illegal.
- Arithmetic and width rules:
  - Shifts use b[$clog2(XLEN)-1:0] only.
  - sra is arithmetic on signed a.
  - Compare ops return zero-extended 0/1.
  - mul returns the low XLEN bits of a 2*XLEN product; mulh/mulhsu/mulhu return the high XLEN bits with ss/su/uu signedness.
- Handshake:
  - Transfer occurs when in_valid && in_ready on a rising edge with rdy=1.
  - in_ready = (state==IDLE) && (!out_valid || out_ack) && !flush.
- States and transitions:
  - IDLE:
    - On accept of ops 0-15: result registered; out_valid=1 next cycle (latency 1); stay IDLE.
    - On accept of mul ops: go to MUL and load counter.
    - On accept of div/rem ops: go to DIV.
  - MUL: counter counts down; at MUL_LAT cycles after accept, result is written and out_valid rises; return to IDLE.
  - DIV: radix-2 restoring iteration, one quotient bit per cycle; out_valid rises XLEN+1 cycles after accept; return to IDLE.
- Output hold:
  - Once out_valid=1, cdb_data, cdb_tag and out_valid stay stable until the cycle out_ack=1; out_valid then drops next edge unless a new result lands in the same edge.
  - Back-to-back single-cycle ops with out_ack held high sustain 1 result/cycle.
- Divide corner cases:
  - divide by zero: div/divu return all ones; rem/remu return a.
  - signed overflow (a = most negative, b = -1): div returns a; rem returns 0.
  - Operand sign fixups are applied at entry; result sign fixups at exit.
- Flush:
  - Synchronous; has priority over everything except reset.
  - Next edge: out_valid=0, cdb_data=0, cdb_tag=0, state=IDLE.
  - Any in-flight mul/div is discarded.
  - in_valid in the flush cycle is ignored.
- Illegal opcode: accepted, no result produced (out_valid stays 0), no state change.
- rdy=0: no transfer, counters frozen, outputs held. An out_ack seen while rdy=0 is ignored.
- Reset mid-operation (rst_n low in any state): immediate return to reset values; no result is emitted afterward.

Optional Feature:
- Macro ALU_MULDIV_DIV_EN.
- Defined: DIV state and ops 20-23 behave as above.
- Undefined:
  - No divider logic is built.
  - Ops 20-23 complete in 1 cycle with cdb_data = all ones and the tag echoed, out_valid=1, so the ROB retires deterministically.
  - MUL behaviour is unchanged.

Test Plan:
- Reset, then issue add a=0x7FFFFFFF b=1 tag=3 with out_ack=1 -> next cycle out_valid=1, cdb_data=0x80000000, cdb_tag=3; one cycle later out_valid=0.
- sra a=0x80000000 b=0x21, then sltu a=1 b=0xFFFFFFFF on back-to-back cycles with ack=1 -> results 0xC0000000 then 1 on consecutive cycles.
- mulh a=0xFFFFFFFF b=0xFFFFFFFF tag=5 with MUL_LAT=3 -> in_ready=0 for 3 cycles; out_valid on cycle 3 with cdb_data=0; mulhu of the same operands -> 0xFFFFFFFE.
- Hold: result ready with out_ack=0 for 4 cycles -> data/tag stable and in_ready=0; out_ack=1 -> out_valid drops next edge and in_ready=1.
- div a=0x80000000 b=0xFFFFFFFF -> 0x80000000 after 33 cycles; rem a=7 b=0 -> 7; divu a=100 b=7 -> 14.
- Flush during DIV cycle 10 -> out_valid never rises for that tag; a new add is accepted the cycle after flush. Separately, rst_n pulsed low mid-MUL -> outputs 0 immediately.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// Integer ALU plus RV32M-style multiply/divide execution unit issuing onto the CDB.
// Build option: define ALU_MULDIV_DIV_EN to include the restoring divider (ops 20-23).
module alu_muldiv_unit #(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 4,
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [4:0]       alu_op,
   input  logic [TAG_W-1:0] tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [XLEN-1:0]  cdb_data,
   output logic [TAG_W-1:0] cdb_tag
);

   localparam int SH_W    = $clog2(XLEN);
   localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  cdb_data_q, cdb_data_d;
   logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
   logic [TAG_W-1:0] ptag_q, ptag_d;
   logic [XLEN-1:0]  acc_q, acc_d;

   logic             accept_s;
   logic             ack_s;
   logic             a_sgn_s;
   logic             b_sgn_s;
   logic [2*XLEN-1:0] a_ext_s;
   logic [2*XLEN-1:0] b_ext_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]  mul_res_s;

   function automatic logic [XLEN-1:0] alu_f(input logic [3:0]      op,
                                             input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
      logic [SH_W-1:0] sh;
      logic            lt_s;
      logic            lt_u;
      sh   = y[SH_W-1:0];
      lt_s = $signed(x) < $signed(y);
      lt_u = x < y;
      case (op)
         4'd0:         alu_f = x + y;
         4'd1:         alu_f = x - y;
         4'd2:         alu_f = x & y;
         4'd3:         alu_f = x | y;
         4'd4:         alu_f = x ^ y;
         4'd5:         alu_f = x << sh;
         4'd6:         alu_f = x >> sh;
         4'd7:         alu_f = $signed(x) >>> sh;
         4'd8, 4'd14:  alu_f = {{(XLEN-1){1'b0}}, lt_s};
         4'd9, 4'd15:  alu_f = {{(XLEN-1){1'b0}}, lt_u};
         4'd10:        alu_f = {{(XLEN-1){1'b0}}, (x == y)};
         4'd11:        alu_f = {{(XLEN-1){1'b0}}, (x != y)};
         4'd12:        alu_f = {{(XLEN-1){1'b0}}, !lt_s};
         4'd13:        alu_f = {{(XLEN-1){1'b0}}, !lt_u};
         default:      alu_f = {XLEN{1'b0}};
      endcase
   endfunction

   assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ack) && !flush;
   assign accept_s  = rdy && in_valid && in_ready;
   assign ack_s     = rdy && out_ack;
   assign out_valid = out_valid_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_tag   = cdb_tag_q;

   // Sign-extend to 2*XLEN so a single multiply covers the ss/su/uu variants
   always_comb begin
      a_sgn_s = (alu_op == 5'd17) || (alu_op == 5'd18);
      b_sgn_s = (alu_op == 5'd17);
      a_ext_s = {{XLEN{a_sgn_s & a[XLEN-1]}}, a};
      b_ext_s = {{XLEN{b_sgn_s & b[XLEN-1]}}, b};
      prod_s  = a_ext_s * b_ext_s;
      if (alu_op == 5'd16) begin
         mul_res_s = prod_s[XLEN-1:0];
      end else begin
         mul_res_s = prod_s[2*XLEN-1:XLEN];
      end
   end

`ifdef ALU_MULDIV_DIV_EN
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            rem_op_q, rem_op_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            dz_q, dz_d;

   logic            div_sgn_s;
   logic            a_neg_s;
   logic            b_neg_s;
   logic [XLEN-1:0] a_abs_s;
   logic [XLEN-1:0] b_abs_s;
   logic [XLEN:0]   rem_sh_s;
   logic [XLEN:0]   diff_s;
   logic [XLEN-1:0] div_res_s;

   // Magnitudes go into the iteration; signs are reapplied when the result is written
   always_comb begin
      div_sgn_s = (alu_op == 5'd20) || (alu_op == 5'd22);
      a_neg_s   = div_sgn_s & a[XLEN-1];
      b_neg_s   = div_sgn_s & b[XLEN-1];
      a_abs_s   = a_neg_s ? (-a) : a;
      b_abs_s   = b_neg_s ? (-b) : b;
      rem_sh_s  = {rem_q, quo_q[XLEN-1]};
      diff_s    = rem_sh_s - {1'b0, dvs_q};
      if (dz_q) begin
         div_res_s = rem_op_q ? acc_q : {XLEN{1'b1}};
      end else if (rem_op_q) begin
         div_res_s = neg_rem_q ? (-rem_q) : rem_q;
      end else begin
         div_res_s = neg_quo_q ? (-quo_q) : quo_q;
      end
   end
`endif

   // Next-state, result capture and output-hold logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      cdb_data_d  = cdb_data_q;
      cdb_tag_d   = cdb_tag_q;
      ptag_d      = ptag_q;
      acc_d       = acc_q;
`ifdef ALU_MULDIV_DIV_EN
      quo_d       = quo_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      rem_op_d    = rem_op_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      dz_d        = dz_q;
`endif
      if (flush) begin
         state_d     = ST_IDLE;
         cnt_d       = {CNT_W{1'b0}};
         out_valid_d = 1'b0;
         cdb_data_d  = {XLEN{1'b0}};
         cdb_tag_d   = {TAG_W{1'b0}};
      end else if (rdy) begin
         if (out_valid_q && ack_s) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  case (alu_op[4:2])
                     3'b000, 3'b001, 3'b010, 3'b011: begin
                        out_valid_d = 1'b1;
                        cdb_data_d  = alu_f(alu_op[3:0], a, b);
                        cdb_tag_d   = tag;
                     end
                     3'b100: begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        acc_d   = mul_res_s;
                        ptag_d  = tag;
                     end
                     3'b101: begin
`ifdef ALU_MULDIV_DIV_EN
                        state_d   = ST_DIV;
                        cnt_d     = CNT_W'(XLEN);
                        ptag_d    = tag;
                        acc_d     = a;
                        quo_d     = a_abs_s;
                        rem_d     = {XLEN{1'b0}};
                        dvs_d     = b_abs_s;
                        rem_op_d  = alu_op[1];
                        neg_quo_d = a_neg_s ^ b_neg_s;
                        neg_rem_d = a_neg_s;
                        dz_d      = (b == {XLEN{1'b0}});
`else
                        out_valid_d = 1'b1;
                        cdb_data_d  = {XLEN{1'b1}};
                        cdb_tag_d   = tag;
`endif
                     end
                     default: begin
                        state_d = ST_IDLE;
                     end
                  endcase
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL: begin
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b1;
                  cdb_data_d  = acc_q;
                  cdb_tag_d   = ptag_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
`ifdef ALU_MULDIV_DIV_EN
            ST_DIV: begin
               if (cnt_q != {CNT_W{1'b0}}) begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (!diff_s[XLEN]) begin
                     rem_d = diff_s[XLEN-1:0];
                     quo_d = {quo_q[XLEN-2:0], 1'b1};
                  end else begin
                     rem_d = rem_sh_s[XLEN-1:0];
                     quo_d = {quo_q[XLEN-2:0], 1'b0};
                  end
               end else begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b1;
                  cdb_data_d  = div_res_s;
                  cdb_tag_d   = ptag_q;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         out_valid_q <= 1'b0;
         cdb_data_q  <= {XLEN{1'b0}};
         cdb_tag_q   <= {TAG_W{1'b0}};
         ptag_q      <= {TAG_W{1'b0}};
         acc_q       <= {XLEN{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         cdb_data_q  <= cdb_data_d;
         cdb_tag_q   <= cdb_tag_d;
         ptag_q      <= ptag_d;
         acc_q       <= acc_d;
      end
   end

`ifdef ALU_MULDIV_DIV_EN
   // Divider working registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q     <= {XLEN{1'b0}};
         rem_q     <= {XLEN{1'b0}};
         dvs_q     <= {XLEN{1'b0}};
         rem_op_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         rem_op_q  <= rem_op_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
      end
   end
`endif

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Randomised and directed bench for alu_muldiv_unit against an arithmetic reference model.
module tb_alu_muldiv_unit;
   localparam int XLEN    = 32;
   localparam int TAG_W   = 4;
   localparam int MUL_LAT = 3;
`ifdef ALU_MULDIV_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   logic        clk, rst_n, rdy, in_valid, in_ready, flush, out_valid, out_ack;
   logic [31:0] a, b, cdb_data;
   logic [4:0]  alu_op;
   logic [3:0]  tag, cdb_tag;

   alu_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_op(alu_op), .tag(tag), .flush(flush),
      .out_valid(out_valid), .out_ack(out_ack), .cdb_data(cdb_data), .cdb_tag(cdb_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   bit checking = 1'b0;

   // Reference model: visible result register plus one pending long-latency result
   bit          m_valid;
   logic [31:0] m_data, m_pdata;
   logic [3:0]  m_tag, m_ptag;
   int          m_busy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      int sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      case (op)
         5'd0:  return x + y;
         5'd1:  return x - y;
         5'd2:  return x & y;
         5'd3:  return x | y;
         5'd4:  return x ^ y;
         5'd5:  return x << y[4:0];
         5'd6:  return x >> y[4:0];
         5'd7:  return sx >>> y[4:0];
         5'd8, 5'd14: return (sx < sy) ? 32'd1 : 32'd0;
         5'd9, 5'd15: return (x < y) ? 32'd1 : 32'd0;
         5'd10: return (x == y) ? 32'd1 : 32'd0;
         5'd11: return (x != y) ? 32'd1 : 32'd0;
         5'd12: return (sx >= sy) ? 32'd1 : 32'd0;
         5'd13: return (x >= y) ? 32'd1 : 32'd0;
         5'd16: begin p = 64'(longint'(sx) * longint'(sy)); return p[31:0]; end
         5'd17: begin p = 64'(longint'(sx) * longint'(sy)); return p[63:32]; end
         5'd18: begin p = 64'(longint'(sx) * longint'({32'd0, y})); return p[63:32]; end
         5'd19: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
         5'd20: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            return sx / sy;
         end
         5'd21: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
         5'd22: begin
            if (y == 32'd0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            return sx % sy;
         end
         5'd23: return (y == 32'd0) ? x : x % y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_ready();
      return (m_busy == 0) && (!m_valid || out_ack) && !flush;
   endfunction

   task automatic m_reset();
      m_valid = 1'b0; m_data = 32'd0; m_tag = 4'd0;
      m_busy = 0; m_pdata = 32'd0; m_ptag = 4'd0;
   endtask

   // Advance the model by one edge using the inputs currently applied, then step the clock
   task automatic cycle();
      bit          n_valid;
      logic [31:0] n_data, n_pdata, r;
      logic [3:0]  n_tag, n_ptag;
      int          n_busy;
      bit          acc;
      acc = rdy && in_valid && m_ready();
      n_valid = m_valid; n_data = m_data; n_tag = m_tag;
      n_busy = m_busy; n_pdata = m_pdata; n_ptag = m_ptag;
      if (!rst_n) begin
         n_valid = 1'b0; n_data = 32'd0; n_tag = 4'd0; n_busy = 0;
      end else if (flush) begin
         n_valid = 1'b0; n_data = 32'd0; n_tag = 4'd0; n_busy = 0;
      end else if (rdy) begin
         if (m_valid && out_ack) n_valid = 1'b0;
         if (m_busy > 0) begin
            n_busy = m_busy - 1;
            if (n_busy == 0) begin
               n_valid = 1'b1; n_data = m_pdata; n_tag = m_ptag;
            end
         end else if (acc) begin
            r = ref_result(alu_op, a, b);
            if (alu_op < 5'd16) begin
               n_valid = 1'b1; n_data = r; n_tag = tag;
            end else if (alu_op < 5'd20) begin
               n_busy = MUL_LAT; n_pdata = r; n_ptag = tag;
            end else if (alu_op < 5'd24) begin
               if (DIV_ON) begin
                  n_busy = XLEN + 1; n_pdata = r; n_ptag = tag;
               end else begin
                  n_valid = 1'b1; n_data = 32'hFFFF_FFFF; n_tag = tag;
               end
            end
         end
      end
      @(posedge clk);
      m_valid = n_valid; m_data = n_data; m_tag = n_tag;
      m_busy = n_busy; m_pdata = n_pdata; m_ptag = n_ptag;
      #1;
   endtask

   // Every cycle: DUT outputs against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("in_ready", in_ready, m_ready());
         chk("out_valid", out_valid, m_valid);
         chk("cdb_data", cdb_data, m_data);
         chk("cdb_tag", cdb_tag, m_tag);
      end
   end

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [3:0] t, input logic [31:0] exp, input int exp_lat);
      int lat;
      a = xa; b = xb; alu_op = op; tag = t; in_valid = 1'b1; out_ack = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 0;
      while (lat < 60 && !out_valid) begin
         cycle();
         lat++;
      end
      chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_data"}, cdb_data, exp);
      chk({name, "_tag"}, cdb_tag, t);
      cycle();
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         4: return $urandom_range(0, 40);
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int div_lat;
      div_lat = DIV_ON ? XLEN + 1 : 0;
      rst_n = 1'b0; rdy = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
      alu_op = 5'd0; tag = 4'd0; flush = 1'b0; out_ack = 1'b0;
      m_reset();

      // Model pins against hand-computed values
      chk("pin_add", ref_result(5'd0, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000);
      chk("pin_sra", ref_result(5'd7, 32'h8000_0000, 32'h21), 32'hC000_0000);
      chk("pin_mulh", ref_result(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'd0);
      chk("pin_mulhu", ref_result(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      chk("pin_div_ovf", ref_result(5'd20, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("pin_rem_dz", ref_result(5'd22, 32'd7, 32'd0), 32'd7);
      chk("pin_divu", ref_result(5'd21, 32'd100, 32'd7), 32'd14);
      chk("pin_div_neg", ref_result(5'd20, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);

      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_cdb_data", cdb_data, 32'd0);
      chk("rst_cdb_tag", cdb_tag, 4'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      checking = 1'b1;

      // add with overflow, one-cycle latency
      a = 32'h7FFF_FFFF; b = 32'd1; alu_op = 5'd0; tag = 4'd3; in_valid = 1'b1; out_ack = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("add_valid", out_valid, 1'b1);
      chk("add_data", cdb_data, 32'h8000_0000);
      chk("add_tag", cdb_tag, 4'd3);
      cycle();
      chk("add_drop", out_valid, 1'b0);

      // back-to-back single-cycle ops
      a = 32'h8000_0000; b = 32'h21; alu_op = 5'd7; tag = 4'd1; in_valid = 1'b1;
      cycle();
      chk("sra_data", cdb_data, 32'hC000_0000);
      a = 32'd1; b = 32'hFFFF_FFFF; alu_op = 5'd9; tag = 4'd2;
      cycle();
      in_valid = 1'b0;
      chk("sltu_valid", out_valid, 1'b1);
      chk("sltu_data", cdb_data, 32'd1);
      cycle();

      run_op("mulh", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'd0, MUL_LAT);

      // mulhu result held while the CDB withholds ack
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; alu_op = 5'd19; tag = 4'd6; in_valid = 1'b1; out_ack = 1'b0;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < MUL_LAT + 4; i++) cycle();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", cdb_data, 32'hFFFF_FFFE);
      chk("hold_ready", in_ready, 1'b0);
      out_ack = 1'b1;
      #1;
      chk("ack_ready", in_ready, 1'b1);
      cycle();
      chk("ack_drop", out_valid, 1'b0);

      run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, DIV_ON ? 32'h8000_0000 : 32'hFFFF_FFFF, div_lat);
      run_op("rem_dz", 5'd22, 32'd7, 32'd0, 4'd8, DIV_ON ? 32'd7 : 32'hFFFF_FFFF, div_lat);
      run_op("divu", 5'd21, 32'd100, 32'd7, 4'd9, DIV_ON ? 32'd14 : 32'hFFFF_FFFF, div_lat);
      run_op("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'd2, 4'd10, DIV_ON ? 32'hFFFF_FFFF : 32'hFFFF_FFFF, div_lat);

      // illegal opcode: accepted, no result
      a = 32'd1; b = 32'd2; alu_op = 5'd27; tag = 4'd4; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("illegal_no_valid", out_valid, 1'b0);
      cycle();

      // flush in the tenth cycle of a divide; the input offered during flush is dropped
      a = 32'd1000; b = 32'd3; alu_op = 5'd20; tag = 4'd9; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) cycle();
      flush = 1'b1; in_valid = 1'b1; alu_op = 5'd0; a = 32'd9; b = 32'd9; tag = 4'hA;
      cycle();
      flush = 1'b0;
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_data", cdb_data, 32'd0);
      a = 32'd2; b = 32'd3; tag = 4'hB;
      #1;
      chk("post_flush_ready", in_ready, 1'b1);
      cycle();
      in_valid = 1'b0;
      chk("post_flush_data", cdb_data, 32'd5);
      chk("post_flush_tag", cdb_tag, 4'hB);
      for (int i = 0; i < 40; i++) cycle();

      // asynchronous reset in the middle of a multiply
      a = 32'd3; b = 32'd5; alu_op = 5'd16; tag = 4'd2; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_data", cdb_data, 32'd0);
      chk("midrst_tag", cdb_tag, 4'd0);
      cycle();
      cycle();
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cycle();

      // randomised traffic with stalls, back-pressure and flushes
      for (int i = 0; i < 4000; i++) begin
         int sel;
         rdy = ($urandom_range(0, 7) != 0);
         in_valid = ($urandom_range(0, 9) < 7);
         sel = $urandom_range(0, 15);
         if (sel < 11)       alu_op = 5'($urandom_range(0, 15));
         else if (sel < 14)  alu_op = 5'($urandom_range(16, 19));
         else if (sel == 14) alu_op = 5'($urandom_range(20, 23));
         else                alu_op = 5'($urandom_range(24, 31));
         a = rnd_opnd();
         b = rnd_opnd();
         tag = 4'($urandom_range(0, 15));
         out_ack = ($urandom_range(0, 3) != 0);
         flush = rdy && ($urandom_range(0, 63) == 0);
         cycle();
      end
      flush = 1'b0; in_valid = 1'b0; rdy = 1'b1; out_ack = 1'b1;
      for (int i = 0; i < 40; i++) cycle();

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
